// File: rtl/spi_master_param.sv
// SPI master with runtime CPOL/CPHA, clock divider, bit order and
// one-hot active-low chip selects. Config is latched on an accepted start.
module spi_master_param #(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_CS     = 4,
  parameter  int CLK_DIV_W  = 8,
  localparam int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  sys_clk,
  input  logic                  cpu_rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [CS_W-1:0]       cs_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  msb_first,
  input  logic [CLK_DIV_W-1:0]  clk_div,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  input  logic                  spi_miso,
  output logic [NUM_CS-1:0]     spi_cs_n
);

  localparam int EW = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [EW-1:0] LAST = EW'(2 * DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CLK_DIV_W-1:0]  cnt;
  logic [CLK_DIV_W-1:0]  div_q;
  logic [EW-1:0]         edge_cnt;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [CS_W-1:0]       cs_q;
  logic                  cpol_q;
  logic                  cpha_q;
  logic                  msb_q;
  logic                  accept;
  logic                  tick;
  logic                  lead;
  logic                  last_edge;
  logic                  smp_en;
  logic                  sh_en;

  function automatic logic head(
    input logic [DATA_WIDTH-1:0] v,
    input logic                  m
  );
    return m ? v[DATA_WIDTH-1] : v[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] adv(
    input logic [DATA_WIDTH-1:0] v,
    input logic                  m
  );
    return m ? {v[DATA_WIDTH-2:0], 1'b0}
             : {1'b0, v[DATA_WIDTH-1:1]};
  endfunction

  assign accept    = (state == IDLE) && start;
  assign tick      = (cnt == div_q);
  assign lead      = ~edge_cnt[0];
  assign last_edge = (edge_cnt == LAST);
  // Sample on leading edge for cpha=0, trailing for cpha=1
  assign smp_en    = (state == XFER) && tick && (lead ^ cpha_q);
  assign sh_en     = (state == XFER) && tick && !(lead ^ cpha_q)
                     && !last_edge;

  always_ff @(posedge sys_clk or negedge cpu_rst) begin
    if (!cpu_rst) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start)             state_nx = SETUP;
      SETUP:   if (tick)              state_nx = XFER;
      XFER:    if (tick && last_edge) state_nx = HOLD;
      HOLD:    if (tick)              state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      cnt      <= '0;
      div_q    <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      cs_q     <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      msb_q    <= 1'b0;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        cnt      <= '0;
        edge_cnt <= '0;
        div_q    <= clk_div;
        cs_q     <= cs_sel;
        cpol_q   <= cpol;
        cpha_q   <= cpha;
        msb_q    <= msb_first;
        spi_sck  <= cpol;
        if (!cpha) begin
          spi_mosi <= head(tx_data, msb_first);
          tx_sr    <= adv(tx_data, msb_first);
        end else begin
          tx_sr    <= tx_data;
        end
      end else if (state != IDLE) begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (state == XFER && tick) begin
          spi_sck  <= ~spi_sck;
          edge_cnt <= edge_cnt + 1'b1;
        end
        if (smp_en) begin
          rx_sr <= msb_q ? {rx_sr[DATA_WIDTH-2:0], spi_miso}
                         : {spi_miso, rx_sr[DATA_WIDTH-1:1]};
        end
        if (sh_en) begin
          spi_mosi <= head(tx_sr, msb_q);
          tx_sr    <= adv(tx_sr, msb_q);
        end
        if (state == HOLD && tick) begin
          spi_sck <= cpol_q;
          done    <= 1'b1;
          rx_data <= rx_sr;
        end
      end
    end
  end

  assign busy = (state != IDLE);

  // Out-of-range cs_sel matches no index, so no select is driven
  always_comb begin
    spi_cs_n = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (busy && cs_q == CS_W'(i)) spi_cs_n[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: vector table through a scoreboard,
// plus busy/back-to-back, reset and 16-bit sequences.
module tb_spi_master_param;

  typedef struct {
    logic [7:0] tx;
    logic       cpol;
    logic       cpha;
    logic       msb;
    logic       inv;
    logic [1:0] cs;
    logic [7:0] div;
    logic [7:0] rx;
    logic [3:0] cs_n;
    int         busy;
  } vec_t;

  typedef struct {
    logic [7:0] rx;
    logic [3:0] cs_n;
    int         busy;
    logic       cpol;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [7:0] tx = '0;
  logic [1:0] cs_sel = '0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       msb = 1'b0;
  logic [7:0] div = '0;
  logic       inv = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] rx;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic [3:0] cs_n;

  assign miso = inv ? ~mosi : mosi;

  spi_master_param u_dut (
    .sys_clk  (clk),
    .cpu_rst  (rst_n),
    .start    (start),
    .tx_data  (tx),
    .cs_sel   (cs_sel),
    .cpol     (cpol),
    .cpha     (cpha),
    .msb_first(msb),
    .clk_div  (div),
    .busy     (busy),
    .done     (done),
    .rx_data  (rx),
    .spi_sck  (sck),
    .spi_mosi (mosi),
    .spi_miso (miso),
    .spi_cs_n (cs_n)
  );

  logic        start2 = 1'b0;
  logic [15:0] tx2 = '0;
  logic [1:0]  cs2 = '0;
  logic        cpol2 = 1'b0;
  logic        cpha2 = 1'b0;
  logic        msb2 = 1'b0;
  logic [7:0]  div2 = '0;
  logic        busy2;
  logic        done2;
  logic [15:0] rx2;
  logic        sck2;
  logic        mosi2;
  logic [2:0]  cs_n2;

  spi_master_param #(
    .DATA_WIDTH(16),
    .NUM_CS    (3),
    .CLK_DIV_W (8)
  ) u_dut16 (
    .sys_clk  (clk),
    .cpu_rst  (rst_n),
    .start    (start2),
    .tx_data  (tx2),
    .cs_sel   (cs2),
    .cpol     (cpol2),
    .cpha     (cpha2),
    .msb_first(msb2),
    .clk_div  (div2),
    .busy     (busy2),
    .done     (done2),
    .rx_data  (rx2),
    .spi_sck  (sck2),
    .spi_mosi (mosi2),
    .spi_miso (mosi2),
    .spi_cs_n (cs_n2)
  );

  int   checks = 0;
  int   errors = 0;
  int   ndone = 0;
  int   exp_done = 0;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  int         busy_len;
  int         rises;
  logic [3:0] cs_obs;
  bit         cs_bad;
  bit         first_busy;
  logic       sck_d;
  logic       busy_d;
  logic       done_d;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_len   = 0;
      rises      = 0;
      cs_bad     = 1'b0;
      first_busy = 1'b1;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      sck_d      = sck;
    end else begin
      if (busy) begin
        busy_len++;
        if (first_busy) begin
          cs_obs     = cs_n;
          first_busy = 1'b0;
        end else if (cs_n !== cs_obs) begin
          cs_bad = 1'b1;
        end
        if (busy_d && sck && !sck_d) rises++;
      end
      if (done) begin
        ndone++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected got=1 want=0");
        end else begin
          e = sb.pop_front();
          chk("rx_data", 32'(rx), 32'(e.rx));
          chk("busy_len", 32'(busy_len), 32'(e.busy));
          chk("sck_rises", 32'(rises), 32'd8);
          chk("cs_n_busy", 32'(cs_obs), 32'(e.cs_n));
          chk("cs_stable", 32'(cs_bad), 32'd0);
          chk("sck_idle", 32'(sck), 32'(e.cpol));
          chk("cs_n_done", 32'(cs_n), 32'hF);
          chk("done_pulse", 32'(done_d), 32'd0);
        end
        busy_len   = 0;
        rises      = 0;
        cs_bad     = 1'b0;
        first_busy = 1'b1;
      end
      sck_d  = sck;
      busy_d = busy;
      done_d = done;
    end
  end

  task automatic apply(input vec_t v);
    tx     = v.tx;
    cpol   = v.cpol;
    cpha   = v.cpha;
    msb    = v.msb;
    inv    = v.inv;
    cs_sel = v.cs;
    div    = v.div;
  endtask

  task automatic push(input vec_t v);
    exp_t e;
    e.rx   = v.rx;
    e.cs_n = v.cs_n;
    e.busy = v.busy;
    e.cpol = v.cpol;
    sb.push_back(e);
    exp_done++;
  endtask

  task automatic scramble();
    tx     = 8'($urandom);
    cpol   = 1'($urandom);
    cpha   = 1'($urandom);
    msb    = 1'($urandom);
    cs_sel = 2'($urandom);
    div    = 8'($urandom);
  endtask

  task automatic start_xfer(input vec_t v);
    @(posedge clk);
    #1;
    apply(v);
    start = 1'b1;
    push(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble();
  endtask

  task automatic wait_done(input int lim);
    int d0;
    bit ok;
    d0 = ndone;
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      @(posedge clk);
      if (ndone != d0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(ok), 32'd1);
  endtask

  task automatic run16(input logic [15:0] t, input logic [1:0] c,
                       input logic [7:0] d, input logic p,
                       input logic h, input logic m,
                       input logic [2:0] ecs, input int eb);
    int bl;
    bit cs_ok;
    bit got;
    @(posedge clk);
    #1;
    tx2 = t; cs2 = c; div2 = d;
    cpol2 = p; cpha2 = h; msb2 = m;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    tx2 = '0; div2 = 8'd9; cpol2 = ~p;
    bl = 0; cs_ok = 1'b1; got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done2) begin
        got = 1'b1;
        break;
      end
      if (busy2) begin
        bl++;
        if (cs_n2 !== ecs) cs_ok = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    chk("w16_done", 32'(got), 32'd1);
    chk("w16_busy_len", 32'(bl), 32'(eb));
    chk("w16_cs_n", 32'(cs_ok), 32'd1);
    chk("w16_rx", 32'(rx2), 32'(t));
    chk("w16_cs_done", 32'(cs_n2), 32'h7);
    chk("w16_sck_idle", 32'(sck2), 32'(p));
    @(posedge clk);
    #1;
    chk("w16_done_pulse", 32'(done2), 32'd0);
  endtask

  vec_t vt[8];
  vec_t va;
  vec_t vb;
  vec_t vr;
  vec_t vl;

  initial begin
    int d0;
    vt[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0,
              8'hA5, 4'b1110, 18};
    vt[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd3,
              8'h3C, 4'b1110, 72};
    vt[2] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0,
              8'h01, 4'b1110, 18};
    vt[3] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd0,
              8'hFE, 4'b1110, 18};
    vt[4] = '{8'h96, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 8'd1,
              8'h96, 4'b1011, 36};
    vt[5] = '{8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 8'd2,
              8'h69, 4'b0111, 54};
    vt[6] = '{8'hC1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0,
              8'hC1, 4'b1101, 18};
    vt[7] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 8'd7,
              8'hA5, 4'b1011, 144};
    va = '{8'h96, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 8'd1,
           8'h96, 4'b1101, 36};
    vb = '{8'h2D, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0,
           8'h2D, 4'b1110, 18};
    vr = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 8'd3,
           8'hA5, 4'b1011, 72};
    vl = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd3,
           8'h01, 4'b1110, 72};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'hF);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_rx", 32'(rx), 32'd0);
    chk("rst16_cs_n", 32'(cs_n2), 32'h7);
    chk("rst16_busy", 32'(busy2), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      start_xfer(vt[i]);
      wait_done(400);
      repeat (2) @(posedge clk);
    end

    start_xfer(vl);
    chk("lsb_first_bit", 32'(mosi), 32'd1);
    repeat (14) @(posedge clk);
    #1;
    chk("lsb_second_bit", 32'(mosi), 32'd0);
    wait_done(200);
    repeat (2) @(posedge clk);

    d0 = ndone;
    start_xfer(va);
    repeat (10) @(posedge clk);
    #1;
    tx = 8'h00; cpol = 1'b1; cpha = 1'b1;
    div = 8'd0; cs_sel = 2'd3; msb = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd1);
    chk("ign_cs_n", 32'(cs_n), 32'(va.cs_n));
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    chk("b2b_done_a", 32'(done), 32'd1);
    apply(vb);
    start = 1'b1;
    push(vb);
    chk("b2b_cs_gap", 32'(cs_n), 32'hF);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_cs_n", 32'(cs_n), 32'(vb.cs_n));
    scramble();
    wait_done(200);
    repeat (4) @(posedge clk);
    chk("b2b_done_count", 32'(ndone - d0), 32'd2);

    start_xfer(vr);
    repeat (30) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", 32'(cs_n), 32'hF);
    chk("midrst_sck", 32'(sck), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_rx", 32'(rx), 32'd0);
    sb.delete();
    exp_done--;
    d0 = ndone;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(ndone), 32'(d0));
    chk("midrst_sck_idle", 32'(sck), 32'd0);

    run16(16'hBEEF, 2'd3, 8'd1, 1'b0, 1'b0, 1'b1, 3'b111, 68);
    run16(16'h1234, 2'd1, 8'd0, 1'b1, 1'b1, 1'b0, 3'b101, 34);

    chk("done_total", 32'(ndone), 32'(exp_done));
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
